lvdt_demod1_status: RTL



---
 rtl/lvdt_demod1_status.sv | 136 +++++++++++++
 1 files changed

// File: rtl/lvdt_demod1_status.sv
// lvdt_demod1_status: Avalon-MM input PIO that collects status flags from
// LVDT demodulator channel 1. Raw status bits are synchronised, edges on
// them are captured into a sticky register, and a maskable level interrupt
// is raised.
//
// Build option: LVDT_STATUS_BITCLR_EN
//   defined   - a write to edge_capture clears only the bits set in writedata
//   undefined - any write to edge_capture clears every bit
//
// Register map (word address):
//   0 data         read = synchronised in_port, writes ignored
//   1 irq_mask     read/write
//   2 reserved     reads 0, writes ignored
//   3 edge_capture sticky captured edges, write clears

module lvdt_demod1_status #(
    parameter int unsigned WIDTH      = 8,      // number of status bits, 1..32
    parameter int unsigned EDGE_TYPE  = 0,      // 0 rising, 1 falling, 2 any
    parameter logic [31:0] RESET_MASK = 32'h0   // reset value of irq_mask
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             read_n,
    input  logic             write_n,
    input  logic [WIDTH-1:0] writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] readdata,
    output logic             irq
);

    localparam logic [1:0] AddrData = 2'd0;
    localparam logic [1:0] AddrMask = 2'd1;
    localparam logic [1:0] AddrRsvd = 2'd2;
    localparam logic [1:0] AddrEdge = 2'd3;

    localparam logic [WIDTH-1:0] MaskInit = RESET_MASK[WIDTH-1:0];

    // Synchroniser stages; s2 is the data value, s3 is only for edge detect.
    logic [WIDTH-1:0] s1_q, s2_q, s3_q;

    logic [WIDTH-1:0] edge_capture_q, edge_capture_d;
    logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic             irq_q, irq_d;

    logic [WIDTH-1:0] rise, fall, edge_det;
    logic [WIDTH-1:0] clr_val, edge_clr;
    logic             wr_en, rd_en;

    assign wr_en = chipselect & ~write_n;
    assign rd_en = chipselect & ~read_n;

    // Three-flop synchroniser for the asynchronous status inputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= in_port;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Edge detection on the synchronised value, polarity chosen at build time.
    always_comb begin
        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;
        if (EDGE_TYPE == 0) begin
            edge_det = rise;
        end else if (EDGE_TYPE == 1) begin
            edge_det = fall;
        end else begin
            edge_det = rise | fall;
        end
    end

    // Clear pattern applied by a write to edge_capture.
    always_comb begin
`ifdef LVDT_STATUS_BITCLR_EN
        clr_val = writedata;
`else
        clr_val = {WIDTH{1'b1}};
`endif
        edge_clr = '0;
        if (wr_en && (address == AddrEdge)) begin
            edge_clr = clr_val;
        end
    end

    // Next state of mask, capture and interrupt; a new edge wins over a clear.
    always_comb begin
        irq_mask_d = irq_mask_q;
        if (wr_en && (address == AddrMask)) begin
            irq_mask_d = writedata;
        end
        edge_capture_d = (edge_capture_q & ~edge_clr) | edge_det;
        irq_d          = |(edge_capture_d & irq_mask_d);
    end

    // Read mux samples current register values, so a same-cycle write is not seen.
    always_comb begin
        readdata_d = readdata_q;
        if (rd_en) begin
            case (address)
                AddrData: readdata_d = s2_q;
                AddrMask: readdata_d = irq_mask_q;
                AddrRsvd: readdata_d = '0;
                AddrEdge: readdata_d = edge_capture_q;
                default:  readdata_d = '0;
            endcase
        end
    end

    // Register state; reset clears capture and drops irq immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_capture_q <= '0;
            irq_mask_q     <= MaskInit;
            readdata_q     <= '0;
            irq_q          <= 1'b0;
        end else begin
            edge_capture_q <= edge_capture_d;
            irq_mask_q     <= irq_mask_d;
            readdata_q     <= readdata_d;
            irq_q          <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
